// File: rtl/param_delay_line.sv
// Runtime-selectable sample delay line (1..MAX_DEPTH clocks).
// Valid travels with data; supports stall, flush and delay reload.
module param_delay_line #(
  parameter int DATA_W        = 12,
  parameter int MAX_DEPTH     = 16,
  parameter int DEPTH_W       = 5,
  parameter int DEFAULT_DELAY = 3
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              ENABLE,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              VALID_IN,
  input  logic [DEPTH_W-1:0] DELAY,
  input  logic              DELAY_LOAD,
  input  logic              FLUSH,
  output logic [DATA_W-1:0] BUF_OUT,
  output logic              VALID_OUT,
  output logic [DEPTH_W-1:0] DELAY_ACT
);

  // BUF_OUT is the last register, so only MAX_DEPTH-1 stages precede it
  localparam int NS = MAX_DEPTH - 1;

  logic [DATA_W-1:0]  stg_data [NS];
  logic [NS-1:0]      stg_vld;
  logic [DATA_W-1:0]  tap_data;
  logic               tap_vld;
  logic [DEPTH_W-1:0] delay_clamp;

  always_comb begin
    delay_clamp = DELAY;
    if (DELAY == '0)
      delay_clamp = DEPTH_W'(1);
    else if (DELAY > DEPTH_W'(MAX_DEPTH))
      delay_clamp = DEPTH_W'(MAX_DEPTH);
  end

  always_comb begin
    tap_data = DATA_IN;
    tap_vld  = VALID_IN;
    for (int i = 0; i < NS; i++) begin
      if (DELAY_ACT == DEPTH_W'(i + 2)) begin
        tap_data = stg_data[i];
        tap_vld  = stg_vld[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NS; i++)
        stg_data[i] <= '0;
      stg_vld   <= '0;
      BUF_OUT   <= '0;
      VALID_OUT <= 1'b0;
    end else if (FLUSH) begin
      for (int i = 0; i < NS; i++)
        stg_data[i] <= '0;
      stg_vld   <= '0;
      BUF_OUT   <= '0;
      VALID_OUT <= 1'b0;
    end else if (ENABLE) begin
      stg_data[0] <= DATA_IN;
      stg_vld[0]  <= VALID_IN;
      for (int i = 1; i < NS; i++) begin
        stg_data[i] <= stg_data[i-1];
        stg_vld[i]  <= stg_vld[i-1];
      end
      BUF_OUT   <= tap_data;
      VALID_OUT <= tap_vld;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      DELAY_ACT <= DEPTH_W'(DEFAULT_DELAY);
    else if (DELAY_LOAD)
      DELAY_ACT <= delay_clamp;
  end

endmodule

// File: tb/tb_param_delay_line.sv
// Directed bench for param_delay_line.
// Covers reset, delay sweep, stall, bubbles, flush+load, async reset.
module tb_param_delay_line;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        ENABLE = 1'b0;
  logic [11:0] DATA_IN = '0;
  logic        VALID_IN = 1'b0;
  logic [4:0]  DELAY = '0;
  logic        DELAY_LOAD = 1'b0;
  logic        FLUSH = 1'b0;
  logic [11:0] BUF_OUT;
  logic        VALID_OUT;
  logic [4:0]  DELAY_ACT;

  int checks = 0;
  int failures = 0;

  param_delay_line #(
    .DATA_W(12), .MAX_DEPTH(16), .DEPTH_W(5), .DEFAULT_DELAY(3)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE),
    .DATA_IN(DATA_IN), .VALID_IN(VALID_IN),
    .DELAY(DELAY), .DELAY_LOAD(DELAY_LOAD), .FLUSH(FLUSH),
    .BUF_OUT(BUF_OUT), .VALID_OUT(VALID_OUT), .DELAY_ACT(DELAY_ACT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic feed(input logic [11:0] d, input logic v);
    DATA_IN  = d;
    VALID_IN = v;
    tick();
  endtask

  // load and flush on one edge with the pipeline stalled
  task automatic setup(input logic [4:0] d);
    ENABLE = 1'b0;
    DELAY = d;
    DELAY_LOAD = 1'b1;
    FLUSH = 1'b1;
    tick();
    DELAY_LOAD = 1'b0;
    FLUSH = 1'b0;
    ENABLE = 1'b1;
  endtask

  initial begin
    int dl [3];
    logic [4:0] dv;
    logic pat [7];
    int j;

    #12;
    check("rst_buf", 32'(BUF_OUT), 0);
    check("rst_vld", 32'(VALID_OUT), 0);
    check("rst_act", 32'(DELAY_ACT), 3);
    @(posedge CLK);
    #1 RESET_N = 1'b1;

    // default delay of 3
    ENABLE = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      feed(12'(k), 1'b1);
      check("def_vld", 32'(VALID_OUT), (k >= 3) ? 1 : 0);
      if (k >= 3) check("def_data", 32'(BUF_OUT), k - 2);
    end
    check("def_act", 32'(DELAY_ACT), 3);

    // delay sweep
    dl = '{1, 7, 16};
    foreach (dl[n]) begin
      ENABLE = 1'b0;
      DELAY = 5'(dl[n]);
      DELAY_LOAD = 1'b1;
      tick();
      DELAY_LOAD = 1'b0;
      check("sw_act", 32'(DELAY_ACT), dl[n]);
      FLUSH = 1'b1;
      tick();
      FLUSH = 1'b0;
      check("sw_flush", 32'(VALID_OUT), 0);
      ENABLE = 1'b1;
      for (int k = 1; k <= dl[n] + 2; k++) begin
        feed(12'(32'h200 + k), 1'b1);
        check("sw_vld", 32'(VALID_OUT), (k >= dl[n]) ? 1 : 0);
        if (k >= dl[n])
          check("sw_data", 32'(BUF_OUT), 32'h200 + k - dl[n] + 1);
      end
    end

    // clamping
    dv = 5'd0;
    DELAY = dv;
    DELAY_LOAD = 1'b1;
    tick();
    check("clamp_lo", 32'(DELAY_ACT), 1);
    dv = 5'd20;
    DELAY = dv;
    tick();
    DELAY_LOAD = 1'b0;
    check("clamp_hi", 32'(DELAY_ACT), 16);

    // stall with D=4
    setup(5'd4);
    for (int k = 0; k <= 18; k++) begin
      feed(12'(32'h100 + k), (k <= 15) ? 1'b1 : 1'b0);
      j = k - 3;
      check("st_vld", 32'(VALID_OUT), (j >= 0 && j <= 15) ? 1 : 0);
      if (j >= 0 && j <= 15)
        check("st_data", 32'(BUF_OUT), 32'h100 + j);
      if (k == 7) begin
        ENABLE = 1'b0;
        for (int s = 0; s < 5; s++) begin
          feed(12'h0EE, 1'b1);
          check("st_hold", 32'(BUF_OUT), 32'h104);
          check("st_hvld", 32'(VALID_OUT), 1);
        end
        ENABLE = 1'b1;
      end
    end

    // bubbles with D=2
    setup(5'd2);
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 7; k++) begin
      feed(12'(32'h30 + k), pat[k]);
      if (k >= 1) begin
        check("bb_vld", 32'(VALID_OUT), 32'(pat[k-1]));
        if (pat[k-1]) check("bb_data", 32'(BUF_OUT), 32'h30 + k - 1);
      end
    end

    // flush and load together while streaming
    for (int k = 0; k < 3; k++) feed(12'(32'h3A0 + k), 1'b1);
    check("fl_pre", 32'(VALID_OUT), 1);
    DELAY = 5'd5;
    DELAY_LOAD = 1'b1;
    FLUSH = 1'b1;
    feed(12'h3FF, 1'b1);
    DELAY_LOAD = 1'b0;
    FLUSH = 1'b0;
    check("fl_vld", 32'(VALID_OUT), 0);
    check("fl_buf", 32'(BUF_OUT), 0);
    check("fl_act", 32'(DELAY_ACT), 5);
    for (int k = 0; k <= 5; k++) begin
      feed(12'(32'h400 + k), 1'b1);
      check("fl5_vld", 32'(VALID_OUT), (k >= 4) ? 1 : 0);
      if (k >= 4) check("fl5_data", 32'(BUF_OUT), 32'h400 + k - 4);
    end

    // async reset between edges
    #3 RESET_N = 1'b0;
    #1;
    check("ar_buf", 32'(BUF_OUT), 0);
    check("ar_vld", 32'(VALID_OUT), 0);
    check("ar_act", 32'(DELAY_ACT), 3);
    tick();
    RESET_N = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
